// File: rtl/uart_frame_rx.sv
// Host-side UART receiver: 8N1 bytes from the MOPSHUB transmitter are packed
// MSB-byte-first into FRAME_W-bit frames and offered on a valid/ready handshake.
module uart_frame_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int N_BYTES      = 10,
    parameter int FRAME_W      = 76,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_serial,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [3:0]         byte_cnt,
    output logic               busy,
    output logic               err_framing,
    output logic               err_timeout,
    output logic               err_overrun
);

    localparam int TMR_W    = $clog2(CLKS_PER_BIT);
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    localparam logic [TMR_W-1:0] HALF_M1 = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_M1 = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_LIMIT - 1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
    localparam logic [3:0]       NB_M1   = 4'(N_BYTES - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    logic               rx_meta_r, rx_sync_r;
    logic [2:0]         state_r, state_s;
    logic [TMR_W-1:0]   timer_r, timer_s;
    logic [2:0]         bit_idx_r, bit_idx_s;
    logic [7:0]         data_r, data_s;
    // Only the low FRAME_W bits are kept; older bytes shift out of the top.
    logic [FRAME_W-1:0] shift_r, shift_s;
    logic [3:0]         byte_cnt_r, byte_cnt_s;
    logic               complete_r, complete_s;
    logic [TO_W-1:0]    to_cnt_r, to_cnt_s;
    logic [FRAME_W-1:0] frame_data_r, frame_data_s;
    logic               frame_valid_r, frame_valid_s;
    logic               busy_r, busy_s;
    logic               err_framing_r, err_framing_s;
    logic               err_timeout_r, err_timeout_s;
    logic               err_overrun_r, err_overrun_s;

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_serial;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Next-state logic for the bit FSM, frame assembly, timeout and handshake.
    always_comb begin
        state_s       = state_r;
        timer_s       = timer_r;
        bit_idx_s     = bit_idx_r;
        data_s        = data_r;
        shift_s       = shift_r;
        byte_cnt_s    = byte_cnt_r;
        complete_s    = 1'b0;
        to_cnt_s      = '0;
        frame_data_s  = frame_data_r;
        frame_valid_s = frame_valid_r;
        err_framing_s = 1'b0;
        err_timeout_s = 1'b0;
        err_overrun_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                timer_s   = '0;
                bit_idx_s = 3'd0;
                if (!rx_sync_r) begin
                    // A start edge always beats a coincident timeout.
                    state_s = ST_START;
                end else if ((byte_cnt_r != 4'd0) && !complete_r) begin
                    if (to_cnt_r == TO_LAST) begin
                        err_timeout_s = 1'b1;
                        byte_cnt_s    = 4'd0;
                        shift_s       = '0;
                    end else begin
                        to_cnt_s = to_cnt_r + TO_ONE;
                    end
                end else begin
                    to_cnt_s = '0;
                end
            end
            ST_START: begin
                if (timer_r == HALF_M1) begin
                    timer_s = '0;
                    if (rx_sync_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    timer_s = timer_r + TMR_ONE;
                end
            end
            ST_DATA: begin
                if (timer_r == FULL_M1) begin
                    timer_s = '0;
                    data_s  = {rx_sync_r, data_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_s = 3'd0;
                        state_s   = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    timer_s = timer_r + TMR_ONE;
                end
            end
            ST_STOP: begin
                if (timer_r == FULL_M1) begin
                    timer_s = '0;
                    if (rx_sync_r) begin
                        shift_s    = {shift_r[FRAME_W-9:0], data_r};
                        byte_cnt_s = byte_cnt_r + 4'd1;
                        complete_s = (byte_cnt_r == NB_M1);
                        state_s    = ST_IDLE;
                    end else begin
                        err_framing_s = 1'b1;
                        byte_cnt_s    = 4'd0;
                        shift_s       = '0;
                        state_s       = ST_WAIT_IDLE;
                    end
                end else begin
                    timer_s = timer_r + TMR_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_sync_r) begin
                    if (timer_r == FULL_M1) begin
                        timer_s = '0;
                        state_s = ST_IDLE;
                    end else begin
                        timer_s = timer_r + TMR_ONE;
                    end
                end else begin
                    timer_s = '0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = '0;
            end
        endcase

        // Completion is handled the cycle after the last stop bit is accepted.
        if (complete_r) begin
            byte_cnt_s = 4'd0;
            if (!frame_valid_r || frame_ready) begin
                frame_data_s  = shift_r;
                frame_valid_s = 1'b1;
            end else begin
                err_overrun_s = 1'b1;
            end
        end else if (frame_valid_r && frame_ready) begin
            frame_valid_s = 1'b0;
        end else begin
            frame_valid_s = frame_valid_r;
        end

        busy_s = (state_s != ST_IDLE) || (byte_cnt_s != 4'd0);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            timer_r       <= '0;
            bit_idx_r     <= 3'd0;
            data_r        <= 8'd0;
            shift_r       <= '0;
            byte_cnt_r    <= 4'd0;
            complete_r    <= 1'b0;
            to_cnt_r      <= '0;
            frame_data_r  <= '0;
            frame_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            err_framing_r <= 1'b0;
            err_timeout_r <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            timer_r       <= timer_s;
            bit_idx_r     <= bit_idx_s;
            data_r        <= data_s;
            shift_r       <= shift_s;
            byte_cnt_r    <= byte_cnt_s;
            complete_r    <= complete_s;
            to_cnt_r      <= to_cnt_s;
            frame_data_r  <= frame_data_s;
            frame_valid_r <= frame_valid_s;
            busy_r        <= busy_s;
            err_framing_r <= err_framing_s;
            err_timeout_r <= err_timeout_s;
            err_overrun_r <= err_overrun_s;
        end
    end

    assign frame_data  = frame_data_r;
    assign frame_valid = frame_valid_r;
    assign byte_cnt    = byte_cnt_r;
    assign busy        = busy_r;
    assign err_framing = err_framing_r;
    assign err_timeout = err_timeout_r;
    assign err_overrun = err_overrun_r;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: stimulus pushes expected frames, a
// negedge monitor pops and compares on every valid&ready transfer.
module tb_uart_frame_rx;

    localparam int CPB = 16;

    logic        clk;
    logic        rst;
    logic        rx_serial;
    logic [75:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  byte_cnt;
    logic        busy;
    logic        err_framing;
    logic        err_timeout;
    logic        err_overrun;

    int tests = 0;
    int fails = 0;
    int xfer_cnt = 0;
    int n_framing = 0;
    int n_timeout = 0;
    int n_overrun = 0;

    logic [75:0] exp_q[$];

    // Frame 1: bytes 0A 12 34 56 78 9A BC DE F0 11; top nibble dropped.
    localparam logic [79:0] F1_BYTES = 80'h0A123456789ABCDEF011;
    localparam logic [75:0] F1_EXP   = 76'hA123456789ABCDEF011;
    // Frame 2: bytes C3 5A A5 3C 0F F0 81 7E 24 DB.
    localparam logic [79:0] F2_BYTES = 80'hC35AA53C0FF0817E24DB;
    localparam logic [75:0] F2_EXP   = 76'h35AA53C0FF0817E24DB;
    localparam logic [79:0] FF_BYTES = 80'hFFFFFFFFFFFFFFFFFFFF;

    uart_frame_rx #(
        .CLKS_PER_BIT(CPB), .N_BYTES(10), .FRAME_W(76), .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk), .rst(rst), .rx_serial(rx_serial),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .byte_cnt(byte_cnt), .busy(busy),
        .err_framing(err_framing), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: transfers, held-frame stability and error pulse accounting.
    logic        prev_hold = 1'b0;
    logic [75:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hold && frame_valid) begin
                check("held_stable", {4'h0, frame_data}, {4'h0, prev_data});
            end
            if (frame_valid && frame_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {4'h0, frame_data}, 80'h0);
                end else begin
                    check("frame_data", {4'h0, frame_data}, {4'h0, exp_q.pop_front()});
                end
            end
            if ((32'(err_framing) + 32'(err_timeout) + 32'(err_overrun)) > 1) begin
                check("err_overlap", {77'h0, err_framing, err_timeout, err_overrun}, 80'h0);
            end
            if (err_framing) n_framing++;
            if (err_timeout) n_timeout++;
            if (err_overrun) n_overrun++;
        end
        prev_hold = frame_valid && !frame_ready && !rst;
        prev_data = frame_data;
    end

    task automatic idle(input int n);
        rx_serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_serial = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx_serial = 1'b1;
    endtask

    task automatic send_frame(input logic [79:0] f);
        for (int i = 9; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
    endtask

    task automatic wait_xfers(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (xfer_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 80'(xfer_cnt), 80'(target));
    endtask

    initial begin
        int n0_f, n0_t, n0_o, n, seen;
        rst = 1'b1;
        rx_serial = 1'b1;
        frame_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_frame_data", {4'h0, frame_data}, 80'h0);
        check("rst_outputs", {73'h0, frame_valid, busy, err_framing, err_timeout, err_overrun, 2'b00},
              80'h0);
        check("rst_byte_cnt", 80'(byte_cnt), 80'h0);
        rst = 1'b0;
        idle(200);
        check("idle_outputs", {70'h0, frame_valid, busy, err_framing, err_timeout, err_overrun, byte_cnt, 1'b0},
              80'h0);

        // Normal frame, consumer always ready.
        exp_q.push_back(F1_EXP);
        send_frame(F1_BYTES);
        wait_xfers("f1_transfer", 1, 60);
        idle(4);
        check("f1_byte_cnt", 80'(byte_cnt), 80'h0);
        check("f1_valid_drop", 80'(frame_valid), 80'h0);

        // Overrun: held frame, second frame dropped.
        frame_ready = 1'b0;
        n0_o = n_overrun;
        exp_q.push_back(F1_EXP);
        send_frame(F1_BYTES);
        idle(20);
        check("ovr_held_valid", 80'(frame_valid), 80'h1);
        send_frame(FF_BYTES);
        idle(20);
        check("ovr_pulse_cnt", 80'(n_overrun - n0_o), 80'h1);
        check("ovr_held_data", {4'h0, frame_data}, {4'h0, F1_EXP});
        frame_ready = 1'b1;
        wait_xfers("ovr_transfer", 2, 20);
        idle(2);
        check("ovr_valid_drop", 80'(frame_valid), 80'h0);

        // Framing error after 3 good bytes, then ignored traffic in WAIT_IDLE.
        n0_f = n_framing;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h55, 1'b0);
        rx_serial = 1'b0;
        repeat (40) @(negedge clk);
        check("frm_pulse_cnt", 80'(n_framing - n0_f), 80'h1);
        check("frm_byte_cnt", 80'(byte_cnt), 80'h0);
        idle(8);
        send_byte(8'h00, 1'b1);
        idle(20);
        check("frm_no_accept", 80'(byte_cnt), 80'h0);
        check("frm_no_extra_err", 80'(n_framing - n0_f), 80'h1);
        exp_q.push_back(F2_EXP);
        send_frame(F2_BYTES);
        wait_xfers("frm_recover", 3, 60);

        // Inter-byte timeout after 4 bytes.
        idle(20);
        n0_t = n_timeout;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h21 + i), 1'b1);
        check("to_byte_cnt4", 80'(byte_cnt), 80'h4);
        n = 0;
        seen = 0;
        while (seen == 0 && n < 400) begin
            @(negedge clk);
            n++;
            if (err_timeout) seen = 1;
        end
        check("to_seen", 80'(seen), 80'h1);
        check("to_latency_window", 80'((n >= 304) && (n <= 324)), 80'h1);
        check("to_byte_cnt0", 80'(byte_cnt), 80'h0);
        idle(4);
        check("to_pulse_cnt", 80'(n_timeout - n0_t), 80'h1);

        // 8-cycle glitch in IDLE is rejected.
        n0_f = n_framing;
        rx_serial = 1'b0;
        repeat (8) @(negedge clk);
        idle(400);
        check("glitch_byte_cnt", 80'(byte_cnt), 80'h0);
        check("glitch_no_err", 80'((n_framing - n0_f) + (n_timeout - n0_t - 1)), 80'h0);
        check("glitch_busy", 80'(busy), 80'h0);

        // Reset mid-byte with a frame held: everything discarded.
        frame_ready = 1'b0;
        send_frame(F1_BYTES);
        idle(20);
        check("rst_pre_valid", 80'(frame_valid), 80'h1);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rx_serial = 1'b1;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_byte_cnt", 80'(byte_cnt), 80'h0);
        check("rst_mid_valid", 80'(frame_valid), 80'h0);
        @(negedge clk);
        rst = 1'b0;
        frame_ready = 1'b1;
        idle(20);
        exp_q.push_back(F2_EXP);
        send_frame(F2_BYTES);
        wait_xfers("rst_recover", 4, 60);
        idle(10);
        check("sb_empty", 80'(exp_q.size()), 80'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
